bnn_conv_stream: RTL and testbench

BNN_CONV_STREAM -- requirements
Module: bnn_conv_stream

---
 rtl/bnn_pkg.sv | 18 +
 rtl/bnn_popcount_thr.sv | 25 ++
 rtl/bnn_conv_stream.sv | 151 +++++++++++++++
 tb/tb_bnn_conv_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Geometry defaults and width helpers shared by the binary conv layers.
package bnn_pkg;

  localparam int DEF_IMG_W = 12;
  localparam int DEF_IMG_H = 12;
  localparam int DEF_CIN   = 8;
  localparam int DEF_COUT  = 16;
  localparam int DEF_K     = 3;

  function automatic int nw_bits(input int k, input int cin);
    return k * k * cin;
  endfunction

  function automatic int pw_bits(input int nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/bnn_popcount_thr.sv
// One output channel: XNOR the window with the kernel, count matches, compare to threshold.
module bnn_popcount_thr #(
  parameter int NW = 72,
  parameter int PW = 7
) (
  input  logic [NW-1:0] window_i,
  input  logic [NW-1:0] weight_i,
  input  logic [PW-1:0] thresh_i,
  output logic          hit_o
);

  logic [NW-1:0] matchBits;
  logic [PW-1:0] matchCount;

  always_comb begin
    matchBits  = ~(window_i ^ weight_i);
    matchCount = '0;
    for (int i = 0; i < NW; i++) begin
      matchCount = matchCount + PW'(matchBits[i]);
    end
  end

  assign hit_o = (matchCount >= thresh_i);

endmodule

// File: rtl/bnn_conv_stream.sv
// Streaming KxK binary convolution: line buffers feed a window, every channel thresholds its popcount.
module bnn_conv_stream
  import bnn_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CIN   = DEF_CIN,
  parameter int COUT  = DEF_COUT,
  parameter int K     = DEF_K,
  localparam int NW   = nw_bits(K, CIN),
  localparam int PW   = pw_bits(NW),
  localparam int AW   = $clog2(COUT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CIN-1:0]  in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [COUT-1:0] out_data,
  input  logic            out_ready,
  output logic            out_last,
  output logic            frame_done,
  input  logic            w_we,
  input  logic [AW-1:0]   w_addr,
  input  logic [NW-1:0]   w_data,
  input  logic [PW-1:0]   th_data,
  output logic            w_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            outValid_q, outValid_d;
  logic [COUT-1:0] outData_q, outData_d;
  logic            outLast_q, outLast_d;
  logic            frameDone_q, wErr_q;

  logic [NW-1:0]   weight_q [COUT];
  logic [PW-1:0]   thresh_q [COUT];
  logic [CIN-1:0]  lineBuf_q [K-1][IMG_W];
  logic [NW-1:0]   winBits_q, winBits_d;
  logic [CIN-1:0]  newColumn [K];

  logic            acceptPix, colLast, rowLast, windowOk, addrOk, writeOk;
  logic [COUT-1:0] chanHit;

  assign in_ready  = !outValid_q || out_ready;
  assign acceptPix = in_valid && in_ready;
  assign colLast   = (col_q == CW'(IMG_W - 1));
  assign rowLast   = (row_q == RW'(IMG_H - 1));
  assign windowOk  = (32'(row_q) >= 32'(K - 1)) && (32'(col_q) >= 32'(K - 1));
  assign addrOk    = (32'(w_addr) < 32'(COUT));
  assign writeOk   = w_we && addrOk && (row_q == '0) && (col_q == '0) && !outValid_q;

  // Column entering the window: oldest row at index 0, the incoming pixel at K-1.
  always_comb begin
    newColumn[K-1] = in_data;
    for (int j = 0; j < K - 1; j++) begin
      newColumn[K-2-j] = lineBuf_q[j][col_q];
    end
  end

  always_comb begin
    winBits_d = winBits_q;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K - 1; kx++) begin
        winBits_d[(ky*K+kx)*CIN +: CIN] = winBits_q[(ky*K+kx+1)*CIN +: CIN];
      end
      winBits_d[(ky*K+K-1)*CIN +: CIN] = newColumn[ky];
    end
  end

  // A write landing on the same edge as a pixel is forwarded into that pixel's window.
  for (genvar o = 0; o < COUT; o++) begin : g_chan
    logic fwdSel;
    assign fwdSel = writeOk && (32'(w_addr) == o);
    bnn_popcount_thr #(.NW(NW), .PW(PW)) u_popThr (
      .window_i (winBits_d),
      .weight_i (fwdSel ? w_data  : weight_q[o]),
      .thresh_i (fwdSel ? th_data : thresh_q[o]),
      .hit_o    (chanHit[o])
    );
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    outValid_d = outValid_q && !out_ready;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    if (acceptPix) begin
      col_d = colLast ? '0 : col_q + CW'(1);
      if (colLast) begin
        row_d = rowLast ? '0 : row_q + RW'(1);
      end
      if (windowOk) begin
        outValid_d = 1'b1;
        outData_d  = chanHit;
        outLast_d  = rowLast && colLast;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acceptPix) begin
      lineBuf_q[0][col_q] <= in_data;
      for (int j = 1; j < K - 1; j++) begin
        lineBuf_q[j][col_q] <= lineBuf_q[j-1][col_q];
      end
      winBits_q <= winBits_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
      frameDone_q <= 1'b0;
      wErr_q      <= 1'b0;
      for (int o = 0; o < COUT; o++) begin
        weight_q[o] <= '0;
        thresh_q[o] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outLast_q   <= outLast_d;
      frameDone_q <= acceptPix && rowLast && colLast;
      wErr_q      <= w_we && !writeOk;
      if (writeOk) begin
        weight_q[w_addr] <= w_data;
        thresh_q[w_addr] <= th_data;
      end
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_last   = outLast_q;
  assign frame_done = frameDone_q;
  assign w_err      = wErr_q;

endmodule

// File: tb/tb_bnn_conv_stream.sv
// Randomized bench for bnn_conv_stream against a direct-convolution reference model.
module tb_bnn_conv_stream;
  import bnn_pkg::*;

  localparam int W   = DEF_IMG_W;
  localparam int H   = DEF_IMG_H;
  localparam int CI  = DEF_CIN;
  localparam int CO  = DEF_COUT;
  localparam int KK  = DEF_K;
  localparam int NWB = KK * KK * CI;
  localparam int PWB = $clog2(NWB + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [CI-1:0]  in_data;
  logic           in_ready;
  logic           out_valid;
  logic [CO-1:0]  out_data;
  logic           out_ready;
  logic           out_last;
  logic           frame_done;
  logic           w_we;
  logic [3:0]     w_addr;
  logic [NWB-1:0] w_data;
  logic [PWB-1:0] th_data;
  logic           w_err;

  always #5 clk = ~clk;

  bnn_conv_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .th_data(th_data),
    .w_err(w_err)
  );

  typedef struct {
    logic [CO-1:0] data;
    logic          last;
  } result_t;

  logic [CI-1:0]  img [H][W];
  logic [NWB-1:0] mW [CO];
  logic [PWB-1:0] mTh [CO];
  result_t        expQ[$];
  int             mRow = 0, mCol = 0;
  logic           expFd = 1'b0, expWerr = 1'b0;

  int checks = 0, errors = 0, totalAcc = 0;
  int frameAcc, resCount, lastCount, litMatch, firstAcc, fdCount, werrCount;
  int lastAt [2];
  int fdAt [2];
  bit seenValid;
  logic [CO-1:0] litExp;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output channel o fires when enough of the KxK window agrees with its kernel.
  function automatic logic [CO-1:0] refConv(input int r, input int c);
    logic [CO-1:0] res;
    int cnt;
    res = '0;
    for (int o = 0; o < CO; o++) begin
      cnt = 0;
      for (int ky = 0; ky < KK; ky++)
        for (int kx = 0; kx < KK; kx++)
          for (int ch = 0; ch < CI; ch++)
            if (img[r-KK+1+ky][c-KK+1+kx][ch] == mW[o][(ky*KK+kx)*CI+ch]) cnt++;
      res[o] = (cnt >= int'(mTh[o]));
    end
    return res;
  endfunction

  always @(negedge clk) begin : monitor
    logic expValid, wrOk, acc, nextFd, nextWerr;
    if (rst) begin
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_w_err", w_err, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      expQ.delete();
      mRow = 0; mCol = 0; expFd = 1'b0; expWerr = 1'b0;
      for (int o = 0; o < CO; o++) begin
        mW[o] = '0; mTh[o] = '0;
      end
    end else begin
      checkOutput("frame_done", frame_done, expFd);
      if (frame_done) begin
        if (fdCount < 2) fdAt[fdCount] = frameAcc;
        fdCount++;
      end
      checkOutput("w_err", w_err, expWerr);
      if (w_err) werrCount++;
      expValid = (expQ.size() != 0);
      checkOutput("out_valid", out_valid, expValid);
      checkOutput("in_ready", in_ready, !expValid || out_ready);
      if (out_valid && !seenValid) begin
        seenValid = 1'b1;
        firstAcc = frameAcc;
      end
      if (expValid) begin
        checkOutput("out_data", out_data, expQ[0].data);
        checkOutput("out_last", out_last, expQ[0].last);
        if (out_ready) begin
          resCount++;
          if (expQ[0].data == litExp) litMatch++;
          if (expQ[0].last) begin
            if (lastCount < 2) lastAt[lastCount] = resCount;
            lastCount++;
          end
          void'(expQ.pop_front());
        end
      end
      nextFd = 1'b0;
      nextWerr = 1'b0;
      wrOk = w_we && (mRow == 0) && (mCol == 0) && !expValid && (int'(w_addr) < CO);
      if (w_we && !wrOk) nextWerr = 1'b1;
      if (wrOk) begin
        mW[w_addr] = w_data;
        mTh[w_addr] = th_data;
      end
      acc = in_valid && (!expValid || out_ready);
      if (acc) begin
        img[mRow][mCol] = in_data;
        totalAcc++;
        frameAcc++;
        if (mRow >= KK - 1 && mCol >= KK - 1)
          expQ.push_back('{refConv(mRow, mCol), (mRow == H - 1) && (mCol == W - 1)});
        if (mRow == H - 1 && mCol == W - 1) nextFd = 1'b1;
        mCol++;
        if (mCol == W) begin
          mCol = 0;
          mRow++;
          if (mRow == H) mRow = 0;
        end
      end
      expFd = nextFd;
      expWerr = nextWerr;
    end
  end

  task automatic clearStats(input logic [CO-1:0] lit);
    frameAcc = 0; resCount = 0; lastCount = 0; litMatch = 0; firstAcc = 0;
    fdCount = 0; werrCount = 0; seenValid = 1'b0; litExp = lit;
    lastAt[0] = 0; lastAt[1] = 0; fdAt[0] = 0; fdAt[1] = 0;
  endtask

  task automatic writeWeights(input bit randomW, input int th);
    for (int o = 0; o < CO; o++) begin
      w_we = 1'b1;
      w_addr = 4'(o);
      w_data = randomW ? {8'($urandom), $urandom, $urandom} : '0;
      th_data = randomW ? 7'($urandom_range(20, 52)) : 7'(th);
      @(posedge clk); #1;
    end
    w_we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives nPix pixels; optional stray write, mid-frame reset and a 5-cycle consumer stall.
  task automatic applyStimulus(input int nPix, input int validPct, input int readyPct,
                               input int pixMode, input int werrAt, input int rstAt,
                               input int stallAt);
    int startAcc, prevAcc, sent, cyc, stallLeft;
    bit consumed, werrDone, stallDone;
    startAcc = totalAcc; prevAcc = totalAcc; cyc = 0; stallLeft = 0;
    werrDone = 1'b0; stallDone = 1'b0;
    forever begin
      sent = totalAcc - startAcc;
      consumed = (totalAcc != prevAcc);
      prevAcc = totalAcc;
      w_we = 1'b0;
      if (sent >= nPix) break;
      if (rstAt >= 0 && sent == rstAt) begin
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (werrAt >= 0 && !werrDone && sent == werrAt) begin
        w_we = 1'b1;
        w_addr = 4'($urandom);
        w_data = {8'($urandom), $urandom, $urandom};
        th_data = 7'($urandom);
        werrDone = 1'b1;
      end
      if (!in_valid || consumed) begin
        in_valid = ($urandom_range(0, 99) < validPct);
        in_data = (pixMode == 0) ? 8'h00 : (pixMode == 1) ? 8'hFF : 8'($urandom);
      end
      if (stallAt >= 0 && !stallDone && sent == stallAt) begin
        stallLeft = 5;
        stallDone = 1'b1;
      end
      if (stallLeft > 0) begin
        out_ready = 1'b0;
        stallLeft--;
      end else begin
        out_ready = ($urandom_range(0, 99) < readyPct);
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 5000) begin
        checkOutput("pixel_budget", sent, nPix);
        break;
      end
    end
    in_valid = 1'b0;
    w_we = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (expQ.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("drain_empty", expQ.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    w_we = 1'b0; w_addr = '0; w_data = '0; th_data = '0;
    clearStats('0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("post_rst_out_data", out_data, 16'h0000);
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Zero weights, zero pixels: every channel sees 72 matches >= 37.
    writeWeights(1'b0, 37);
    clearStats(16'hFFFF);
    applyStimulus(144, 100, 100, 0, -1, -1, -1);
    drain();
    checkOutput("zero_results", resCount, 100);
    checkOutput("zero_all_ffff", litMatch, 100);
    checkOutput("zero_first_latency", firstAcc, 27);
    checkOutput("zero_last_count", lastCount, 1);
    checkOutput("zero_last_index", lastAt[0], 100);
    checkOutput("zero_frame_done_at", fdAt[0], 144);

    // Ones pixels against zero kernels: zero matches.
    writeWeights(1'b0, 1);
    clearStats(16'h0000);
    applyStimulus(144, 100, 100, 1, -1, -1, -1);
    drain();
    checkOutput("th1_all_0000", litMatch, 100);
    writeWeights(1'b0, 0);
    clearStats(16'hFFFF);
    applyStimulus(144, 100, 100, 1, -1, -1, -1);
    drain();
    checkOutput("th0_all_ffff", litMatch, 100);

    // Random kernels with a forced consumer stall, then random handshakes.
    writeWeights(1'b1, 0);
    clearStats('0);
    applyStimulus(144, 100, 100, 2, -1, -1, 40);
    drain();
    checkOutput("stall_results", resCount, 100);
    clearStats('0);
    applyStimulus(144, 70, 60, 2, -1, -1, 60);
    drain();
    checkOutput("random_results", resCount, 100);

    // Two frames with no gap between them.
    clearStats('0);
    applyStimulus(288, 100, 100, 2, -1, -1, -1);
    drain();
    checkOutput("b2b_results", resCount, 200);
    checkOutput("b2b_last_count", lastCount, 2);
    checkOutput("b2b_last_first", lastAt[0], 100);
    checkOutput("b2b_last_second", lastAt[1], 200);
    checkOutput("b2b_done_count", fdCount, 2);
    checkOutput("b2b_done_first", fdAt[0], 144);
    checkOutput("b2b_done_second", fdAt[1], 288);

    // Rejected mid-frame write, then reset mid-frame and a fresh frame.
    clearStats('0);
    applyStimulus(144, 100, 100, 2, 50, 70, -1);
    checkOutput("werr_pulses", werrCount, 1);
    out_ready = 1'b1;
    writeWeights(1'b1, 0);
    clearStats('0);
    applyStimulus(144, 100, 100, 2, -1, -1, -1);
    drain();
    checkOutput("after_rst_latency", firstAcc, 27);
    checkOutput("after_rst_results", resCount, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
